parking_gate_ctrl: RTL and testbench

// - Upstream lane controller for the parking occupancy counter: one entry lane, one exit lane.
// - Debounces loop/beam sensors, checks vacancy flags, drives both barriers.
// - Emits registered 1-cycle car_entered/car_exited pulses (+ uni qualifiers) that the counter consumes.
// - Guarantees at most one event per cycle, because the counter gives entry priority over exit.

---
 rtl/parking_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
// Lane controller in front of the parking occupancy counter. It runs one entry
// lane and one exit lane. It debounces the loop and beam sensors, checks the
// vacancy flags, drives both barriers, and emits 1-cycle pass events.
//
// Optional feature: define GATE_STATS_EN to add the rej_count and tmo_count
// outputs. These are saturating counts of refused entries and entry timeouts.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   en_loop, en_pass          raw entry loop and beam sensors
//   en_badge_valid/_uni       1-cycle badge strobe and its class (1 = university)
//   ex_loop, ex_pass          raw exit loop and beam sensors
//   ex_is_uni                 exit vehicle class, sampled on debounced ex_loop rise
//   uni_is_vacated_space      counter reports a university space is free
//   is_vacated_space          counter reports a public space is free
//   en_barrier_open           entry barrier drive
//   ex_barrier_open           exit barrier drive
//   car_entered/_exited       1-cycle events to the counter, never high together
//   is_uni_car_entered/exited class of the event; 0 when no event is present
//   en_reject, en_timeout     1-cycle entry refusal and entry timeout pulses
//   dbg_en_state, dbg_ex_state  current FSM states, for observation only
//
// Handshake: the event outputs are valid-only pulses with no ready signal. The
// counter must accept every pulse. This block arbitrates internally, so at most
// one event is presented per cycle.
module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int OPEN_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_loop,
  input  logic        en_badge_valid,
  input  logic        en_badge_uni,
  input  logic        en_pass,
  input  logic        ex_loop,
  input  logic        ex_is_uni,
  input  logic        ex_pass,
  input  logic        uni_is_vacated_space,
  input  logic        is_vacated_space,
  output logic        en_barrier_open,
  output logic        ex_barrier_open,
  output logic        car_entered,
  output logic        is_uni_car_entered,
  output logic        car_exited,
  output logic        is_uni_car_exited,
  output logic        en_reject,
  output logic        en_timeout,
  output logic [2:0]  dbg_en_state,
  output logic [2:0]  dbg_ex_state
`ifdef GATE_STATS_EN
  ,
  output logic [15:0] rej_count,
  output logic [15:0] tmo_count
`endif
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = ($clog2(OPEN_TIMEOUT + 1) > 10) ? $clog2(OPEN_TIMEOUT + 1) : 10;

  typedef enum logic [2:0] {
    EN_IDLE, EN_WAIT_BADGE, EN_CHECK, EN_OPEN, EN_REJECT, EN_COMMIT, EN_CLOSE
  } en_state_e;

  typedef enum logic [2:0] {
    EX_IDLE, EX_OPEN, EX_COMMIT, EX_CLOSE
  } ex_state_e;

  // Sensor order: 0 en_loop, 1 en_pass, 2 ex_loop, 3 ex_pass
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q, deb_q;
  logic [CW-1:0] cnt_q [4];
  logic          en_pass_prev_q, ex_loop_prev_q, ex_pass_prev_q;

  assign raw = {ex_pass, ex_loop, en_pass, en_loop};

  // A synchronized bit must disagree with its debounced value for DEBOUNCE
  // consecutive cycles before the debounced value follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      en_pass_prev_q <= 1'b0;
      ex_loop_prev_q <= 1'b0;
      ex_pass_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q        <= raw;
      sync2_q        <= sync1_q;
      en_pass_prev_q <= deb_q[1];
      ex_loop_prev_q <= deb_q[2];
      ex_pass_prev_q <= deb_q[3];
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic en_loop_d, en_pass_d, ex_loop_d, ex_pass_d;
  logic en_pass_rise, ex_loop_rise, ex_pass_rise;
  assign en_loop_d    = deb_q[0];
  assign en_pass_d    = deb_q[1];
  assign ex_loop_d    = deb_q[2];
  assign ex_pass_d    = deb_q[3];
  assign en_pass_rise = en_pass_d & ~en_pass_prev_q;
  assign ex_loop_rise = ex_loop_d & ~ex_loop_prev_q;
  assign ex_pass_rise = ex_pass_d & ~ex_pass_prev_q;

  en_state_e     en_state_q;
  ex_state_e     ex_state_q;
  logic          en_uni_q, ex_uni_q;
  logic [TW-1:0] timer_q;
  logic          en_barrier_q, ex_barrier_q, en_reject_q, en_timeout_q;
  logic          en_req, ex_req, en_grant, ex_grant, vac_ok;

  // Entry always wins. A waiting exit stays in COMMIT until a cycle arrives
  // in which entry is not requesting.
  assign en_req   = (en_state_q == EN_COMMIT);
  assign ex_req   = (ex_state_q == EX_COMMIT);
  assign en_grant = en_req;
  assign ex_grant = ex_req & ~en_req;
  assign vac_ok   = en_uni_q ? uni_is_vacated_space : is_vacated_space;

  // Entry lane FSM. Vacancy is looked at only in CHECK. Once the barrier is
  // open, a flag drop does not close it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_state_q   <= EN_IDLE;
      en_uni_q     <= 1'b0;
      timer_q      <= '0;
      en_barrier_q <= 1'b0;
      en_reject_q  <= 1'b0;
      en_timeout_q <= 1'b0;
    end else begin
      en_reject_q  <= 1'b0;
      en_timeout_q <= 1'b0;
      case (en_state_q)
        EN_IDLE:       if (en_loop_d) en_state_q <= EN_WAIT_BADGE;
        EN_WAIT_BADGE: begin
          if (!en_loop_d) begin
            en_state_q <= EN_IDLE;
          end else if (en_badge_valid) begin
            en_state_q <= EN_CHECK;
            en_uni_q   <= en_badge_uni;
          end
        end
        EN_CHECK: begin
          if (vac_ok) begin
            en_state_q   <= EN_OPEN;
            en_barrier_q <= 1'b1;
            timer_q      <= '0;
          end else begin
            en_state_q  <= EN_REJECT;
            en_reject_q <= 1'b1;
          end
        end
        EN_REJECT:     if (!en_loop_d) en_state_q <= EN_IDLE;
        EN_OPEN: begin
          // timer_q counts completed OPEN cycles. The last one expires here.
          if (en_pass_rise) begin
            en_state_q <= EN_COMMIT;
          end else if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
            en_state_q   <= EN_IDLE;
            en_barrier_q <= 1'b0;
            en_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        EN_COMMIT: begin
          if (en_grant) begin
            en_state_q   <= EN_CLOSE;
            en_barrier_q <= 1'b0;
          end
        end
        EN_CLOSE:      if (!en_loop_d && !en_pass_d) en_state_q <= EN_IDLE;
        default:       en_state_q <= EN_IDLE;
      endcase
    end
  end

  // Exit lane FSM. The exit barrier has no timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_state_q   <= EX_IDLE;
      ex_uni_q     <= 1'b0;
      ex_barrier_q <= 1'b0;
    end else begin
      case (ex_state_q)
        EX_IDLE: begin
          if (ex_loop_rise) begin
            ex_state_q   <= EX_OPEN;
            ex_uni_q     <= ex_is_uni;
            ex_barrier_q <= 1'b1;
          end
        end
        EX_OPEN:   if (ex_pass_rise) ex_state_q <= EX_COMMIT;
        EX_COMMIT: begin
          if (ex_grant) begin
            ex_state_q   <= EX_CLOSE;
            ex_barrier_q <= 1'b0;
          end
        end
        EX_CLOSE:  if (!ex_loop_d && !ex_pass_d) ex_state_q <= EX_IDLE;
        default:   ex_state_q <= EX_IDLE;
      endcase
    end
  end

  // A grant in cycle N produces the event pulse in cycle N+1.
  logic car_entered_q, uni_entered_q, car_exited_q, uni_exited_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_entered_q <= 1'b0;
      uni_entered_q <= 1'b0;
      car_exited_q  <= 1'b0;
      uni_exited_q  <= 1'b0;
    end else begin
      car_entered_q <= en_grant;
      uni_entered_q <= en_grant & en_uni_q;
      car_exited_q  <= ex_grant;
      uni_exited_q  <= ex_grant & ex_uni_q;
    end
  end

`ifdef GATE_STATS_EN
  logic [15:0] rej_cnt_q, tmo_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (en_reject_q && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      if (en_timeout_q && tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
  assign rej_count = rej_cnt_q;
  assign tmo_count = tmo_cnt_q;
`endif

  assign en_barrier_open    = en_barrier_q;
  assign ex_barrier_open    = ex_barrier_q;
  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = uni_entered_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_exited  = uni_exited_q;
  assign en_reject          = en_reject_q;
  assign en_timeout         = en_timeout_q;
  assign dbg_en_state       = en_state_q;
  assign dbg_ex_state       = ex_state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl with DEBOUNCE=4 and OPEN_TIMEOUT=20.
// Stimulus pushes the expected event codes into exp_q. The monitor pops one
// entry each time the DUT presents any event or pulse output.
// Event code: {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
//              en_reject, en_timeout}
module tb_parking_gate_ctrl;
  localparam int W = 6;
  localparam logic [W-1:0] EV_ENTER_UNI = 6'b110000;
  localparam logic [W-1:0] EV_ENTER_PUB = 6'b100000;
  localparam logic [W-1:0] EV_EXIT_UNI  = 6'b001100;
  localparam logic [W-1:0] EV_REJECT    = 6'b000010;
  localparam logic [W-1:0] EV_TIMEOUT   = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_loop = 0, en_badge_valid = 0, en_badge_uni = 0, en_pass = 0;
  logic ex_loop = 0, ex_is_uni = 0, ex_pass = 0;
  logic uni_is_vacated_space = 0, is_vacated_space = 0;
  logic en_barrier_open, ex_barrier_open, car_entered, is_uni_car_entered;
  logic car_exited, is_uni_car_exited, en_reject, en_timeout;
  logic [2:0] dbg_en_state, dbg_ex_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  parking_gate_ctrl #(.DEBOUNCE(4), .OPEN_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .en_loop(en_loop), .en_badge_valid(en_badge_valid), .en_badge_uni(en_badge_uni),
    .en_pass(en_pass), .ex_loop(ex_loop), .ex_is_uni(ex_is_uni), .ex_pass(ex_pass),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .en_barrier_open(en_barrier_open), .ex_barrier_open(ex_barrier_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .en_reject(en_reject), .en_timeout(en_timeout),
    .dbg_en_state(dbg_en_state), .dbg_ex_state(dbg_ex_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return en_barrier_open;
      1:       return ex_barrier_open;
      2:       return car_entered;
      3:       return dbg_en_state == 3'd0;
      default: return dbg_ex_state == 3'd0;
    endcase
  endfunction

  // Bounded wait, sampled on the falling edge. An expired budget counts as a failure.
  task automatic wait_until(input int which, input logic val, input int budget, input string name);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (sig(which) === val) break;
      n++;
    end
    total++;
    if (sig(which) !== val) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b within %0d cycles", name, sig(which), val, budget);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic badge(input logic uni);
    en_badge_uni   = uni;
    en_badge_valid = 1'b1;
    step(1);
    en_badge_valid = 1'b0;
  endtask

  task automatic open_entry(input logic uni, input string name);
    en_loop = 1'b1;
    step(8);
    badge(uni);
    wait_until(0, 1'b1, 10, name);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] code, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        code = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                en_reject, en_timeout};
        if (code != '0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %b expected none", code);
          end else begin
            e = exp_q.pop_front();
            if (code !== e) begin
              bad++;
              $display("FAIL event: got %b expected %b", code, e);
            end
          end
        end
      end
    end
  end

  initial begin
    int errs, hi;
    // reset state
    step(3);
    check("rst_en_barrier", en_barrier_open, 0);
    check("rst_ex_barrier", ex_barrier_open, 0);
    check("rst_car_entered", car_entered, 0);
    check("rst_car_exited", car_exited, 0);
    check("rst_reject", en_reject, 0);
    check("rst_timeout", en_timeout, 0);
    check("rst_en_state", dbg_en_state, 0);
    check("rst_ex_state", dbg_ex_state, 0);
    rst = 1'b0;
    step(2);

    // uni entry
    uni_is_vacated_space = 1'b1;
    is_vacated_space     = 1'b1;
    exp_q.push_back(EV_ENTER_UNI);
    open_entry(1'b1, "uni_open");
    step(1);
    en_pass = 1'b1;
    step(10);
    en_pass = 1'b0;
    wait_until(0, 1'b0, 20, "uni_barrier_close");
    en_loop = 1'b0;
    wait_until(3, 1'b1, 20, "uni_idle");
    check("uni_barrier_after", en_barrier_open, 0);
    check("uni_sb_drained", exp_q.size(), 0);

    // public badge with no public space; the uni flag is 1 to expose a wrong flag choice
    uni_is_vacated_space = 1'b1;
    is_vacated_space     = 1'b0;
    exp_q.push_back(EV_REJECT);
    en_loop = 1'b1;
    step(8);
    badge(1'b0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (en_barrier_open) hi++;
    end
    check("full_barrier_never_open", hi, 0);
    check("full_state_reject", dbg_en_state, 3'd4);
    step(1);
    en_loop = 1'b0;
    wait_until(3, 1'b1, 20, "full_idle");

    // timeout: the barrier must stay open for exactly 20 cycles
    is_vacated_space = 1'b1;
    exp_q.push_back(EV_TIMEOUT);
    open_entry(1'b0, "tmo_open");
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!en_barrier_open) break;
      hi++;
    end
    check("tmo_open_cycles", hi, 20);
    check("tmo_barrier_closed", en_barrier_open, 0);
    step(1);
    en_loop = 1'b0;
    wait_until(3, 1'b1, 20, "tmo_idle");

    // collision: both lanes commit in the same cycle; public entry requires is_vacated_space
    uni_is_vacated_space = 1'b0;
    is_vacated_space     = 1'b1;
    ex_is_uni = 1'b1;
    ex_loop   = 1'b1;
    open_entry(1'b0, "coll_en_open");
    check("coll_ex_open", ex_barrier_open, 1);
    ex_is_uni = 1'b0;
    exp_q.push_back(EV_ENTER_PUB);
    exp_q.push_back(EV_EXIT_UNI);
    step(1);
    en_pass = 1'b1;
    ex_pass = 1'b1;
    wait_until(2, 1'b1, 15, "coll_entered");
    check("coll_no_exit_with_entry", car_exited, 0);
    @(negedge clk);
    check("coll_entered_one_cycle", car_entered, 0);
    check("coll_exited_next", car_exited, 1);
    check("coll_exit_uni", is_uni_car_exited, 1);
    @(negedge clk);
    check("coll_exited_one_cycle", car_exited, 0);
    step(1);
    en_pass = 1'b0;
    ex_pass = 1'b0;
    en_loop = 1'b0;
    ex_loop = 1'b0;
    wait_until(3, 1'b1, 20, "coll_en_idle");
    wait_until(4, 1'b1, 20, "coll_ex_idle");
    check("coll_ex_barrier_closed", ex_barrier_open, 0);

    // glitch shorter than the debounce window, plus a badge strobe outside WAIT_BADGE
    en_loop = 1'b1;
    step(2);
    en_loop = 1'b0;
    badge(1'b1);
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dbg_en_state != 3'd0 || en_barrier_open) errs++;
    end
    check("glitch_stays_idle", errs, 0);

    // asynchronous reset while the entry barrier is open and a pass is pending
    uni_is_vacated_space = 1'b1;
    open_entry(1'b1, "rst_mid_open");
    step(1);
    en_pass = 1'b1;
    step(5);
    rst = 1'b1;
    #1;
    check("rst_barrier_immediate", en_barrier_open, 0);
    check("rst_state_immediate", dbg_en_state, 0);
    step(2);
    rst = 1'b0;
    step(3);
    en_loop = 1'b0;
    en_pass = 1'b0;
    step(15);
    check("rst_after_idle", dbg_en_state, 0);

    // wait a bounded time for any outstanding expected events
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_empty_at_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
